// File: rtl/seven_seg_to_bcd_capture_pkg.sv
// rtl/seven_seg_to_bcd_capture_pkg.sv - shared constants and state encoding for seven-segment readback
package seven_seg_to_bcd_capture_pkg;

    // Segment bit positions on the sampled bus (bit0=a .. bit6=g, bit7=dp)
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Lit-segment patterns for the ten legal digits
    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;

    // Reported in place of a digit whose pattern is not one of the above
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } cap_state_t;

endpackage

// File: rtl/seven_seg_to_bcd_capture_seg_pattern_decode.sv
// rtl/seven_seg_to_bcd_capture_seg_pattern_decode.sv - 7-bit segment pattern to {err, bcd}
module seg_pattern_decode
    import seven_seg_to_bcd_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       err
);

    // Map each legal pattern back to its digit; blank and partial patterns are errors
    always_comb begin
        bcd = BCD_INVALID;
        err = 1'b1;
        case (pattern)
            PAT_0: begin bcd = 4'd0; err = 1'b0; end
            PAT_1: begin bcd = 4'd1; err = 1'b0; end
            PAT_2: begin bcd = 4'd2; err = 1'b0; end
            PAT_3: begin bcd = 4'd3; err = 1'b0; end
            PAT_4: begin bcd = 4'd4; err = 1'b0; end
            PAT_5: begin bcd = 4'd5; err = 1'b0; end
            PAT_6: begin bcd = 4'd6; err = 1'b0; end
            PAT_7: begin bcd = 4'd7; err = 1'b0; end
            PAT_8: begin bcd = 4'd8; err = 1'b0; end
            PAT_9: begin bcd = 4'd9; err = 1'b0; end
            default: begin bcd = BCD_INVALID; err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_to_bcd_capture.sv
// rtl/seven_seg_to_bcd_capture.sv - recovers per-digit BCD frames from a multiplexed seven-segment bus
module seven_seg_to_bcd_capture
    import seven_seg_to_bcd_capture_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   err_out,
    output logic                    sel_err
);

    localparam int              CW      = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT);

    logic [3:0]                     dec_bcd;
    logic                           dec_err;
    logic                           an_onehot;
    logic                           valid_sample;
    logic [NUM_DIGITS-1:0]          cap_hit;
    logic [NUM_DIGITS-1:0][7:0]     last_pat;
    logic [NUM_DIGITS-1:0][CW-1:0]  cnt;
    logic [NUM_DIGITS-1:0]          captured;
    logic [4*NUM_DIGITS-1:0]        shadow_bcd;
    logic [NUM_DIGITS-1:0]          shadow_dp;
    logic [NUM_DIGITS-1:0]          shadow_err;
    cap_state_t                     state;

    // Only one digit is on the bus per cycle, so a single decoder serves all digits
    seg_pattern_decode u_decode (
        .pattern (seg_in[SEG_G:SEG_A]),
        .bcd     (dec_bcd),
        .err     (dec_err)
    );

    assign an_onehot    = (an_in != '0) && ((an_in & (an_in - NUM_DIGITS'(1))) == '0);
    assign valid_sample = sample_en && an_onehot;

    // Flag the sample that makes a digit's run length reach the stability threshold
    always_comb begin
        cap_hit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (valid_sample && an_in[i]) begin
                if (seg_in == last_pat[i]) begin
                    cap_hit[i] = (cnt[i] != CNT_MAX) && ((cnt[i] + CW'(1)) == CNT_MAX);
                end else begin
                    cap_hit[i] = (STABLE_CNT == 1);
                end
            end
        end
    end

    // Per-digit stability filter and shadow capture of the decoded digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pat   <= '0;
            cnt        <= '0;
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            shadow_err <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (valid_sample && an_in[i]) begin
                    if (seg_in == last_pat[i]) begin
                        if (cnt[i] != CNT_MAX) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end else begin
                        last_pat[i] <= seg_in;
                        cnt[i]      <= CW'(1);
                    end
                    if (cap_hit[i]) begin
                        shadow_bcd[4*i +: 4] <= dec_bcd;
                        shadow_dp[i]         <= seg_in[SEG_DP];
                        shadow_err[i]        <= dec_err;
                    end
                end
            end
        end
    end

    // Sticky flag for any strobe whose digit select was not exactly one-hot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else if (sample_en && !an_onehot) begin
            sel_err <= 1'b1;
        end
    end

    // Frame FSM: gather a full captured mask, then hold the frame until the consumer takes it.
    // A capture landing on the load cycle belongs to the next frame, so it survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_COLLECT;
            captured    <= '0;
            frame_valid <= 1'b0;
            bcd_out     <= '0;
            dp_out      <= '0;
            err_out     <= '0;
        end else begin
            captured <= captured | cap_hit;
            case (state)
                ST_COLLECT: begin
                    if (&captured) begin
                        bcd_out     <= shadow_bcd;
                        dp_out      <= shadow_dp;
                        err_out     <= shadow_err;
                        captured    <= cap_hit;
                        frame_valid <= 1'b1;
                        state       <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        state       <= ST_COLLECT;
                    end
                end
                default: begin
                    frame_valid <= 1'b0;
                    state       <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_to_bcd_capture.sv
// tb/tb_seven_seg_to_bcd_capture.sv - self-checking bench for seven_seg_to_bcd_capture
module tb_seven_seg_to_bcd_capture;

    localparam int N = 4;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           sample_en = 1'b0;
    logic [7:0]     seg_in = '0;
    logic [N-1:0]   an_in = '0;
    logic           frame_valid;
    logic           frame_ready = 1'b0;
    logic [4*N-1:0] bcd_out;
    logic [N-1:0]   dp_out;
    logic [N-1:0]   err_out;
    logic           sel_err;

    int tests = 0;
    int fails = 0;

    seven_seg_to_bcd_capture #(.NUM_DIGITS(N), .STABLE_CNT(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .bcd_out     (bcd_out),
        .dp_out      (dp_out),
        .err_out     (err_out),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    // Reference model: run length of identical samples per digit, capture when it hits S exactly
    logic [6:0]  legal_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [7:0]  m_last [N];
    int          m_run [N];
    logic [3:0]  m_dig [N];
    logic        m_dp [N];
    logic        m_err [N];
    logic [N-1:0] m_cap;
    logic        m_present;
    logic        m_sel_err;
    logic [15:0] e_bcd;
    logic [3:0]  e_dp;
    logic [3:0]  e_err;

    typedef struct packed {
        logic [3:0][7:0] pat;
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic [3:0]      err;
    } vec_t;

    vec_t rows [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_digit(input logic [7:0] seg);
        for (int k = 0; k < 10; k++) begin
            if (legal_pat[k] == seg[6:0]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_last[d] = 8'h00; m_run[d] = 0; m_dig[d] = 4'h0; m_dp[d] = 1'b0; m_err[d] = 1'b0;
        end
        m_cap = '0; m_present = 1'b0; m_sel_err = 1'b0;
        e_bcd = '0; e_dp = '0; e_err = '0;
    endtask

    task automatic model_step(input logic se, input logic [3:0] an, input logic [7:0] seg, input logic rdy);
        int d;
        int v;
        if (se && $countones(an) != 1) m_sel_err = 1'b1;
        if (!m_present) begin
            if (m_cap == '1) begin
                for (int k = 0; k < N; k++) begin
                    e_bcd[4*k +: 4] = m_dig[k]; e_dp[k] = m_dp[k]; e_err[k] = m_err[k];
                end
                m_present = 1'b1;
                m_cap = '0;
            end
        end else if (rdy) begin
            m_present = 1'b0;
        end
        if (se && $countones(an) == 1) begin
            d = 0;
            for (int k = 0; k < N; k++) if (an[k]) d = k;
            if (seg == m_last[d]) m_run[d]++;
            else begin m_last[d] = seg; m_run[d] = 1; end
            if (m_run[d] == S) begin
                v = ref_digit(seg);
                m_dig[d] = (v < 0) ? 4'hF : 4'(v);
                m_err[d] = (v < 0);
                m_dp[d]  = seg[7];
                m_cap[d] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic se, input logic [3:0] an, input logic [7:0] seg, input logic rdy);
        sample_en = se; an_in = an; seg_in = seg; frame_ready = rdy;
        model_step(se, an, seg, rdy);
        @(posedge clk); #1;
        check("model_fv", frame_valid, m_present);
        check("model_bcd", bcd_out, e_bcd);
        check("model_dp", dp_out, e_dp);
        check("model_err", err_out, e_err);
        check("model_sel_err", sel_err, m_sel_err);
    endtask

    task automatic strobe(input int d, input logic [7:0] seg, input int n, input logic rdy);
        repeat (n) tick(1'b1, 4'(1) << d, seg, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) tick(1'b0, 4'b0000, 8'h00, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sample_en = 1'b0; an_in = '0; seg_in = '0; frame_ready = 1'b0;
        #1;
        model_reset();
        check("rst_fv", frame_valid, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_dp", dp_out, 0);
        check("rst_err", err_out, 0);
        check("rst_sel_err", sel_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_frame(input logic rdy);
        for (int k = 0; k < 10; k++) begin
            if (frame_valid) break;
            idle(1, rdy);
        end
        check("frame_timeout", frame_valid, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] cur_an;
        logic [7:0] cur_seg [N];
        logic [7:0] pool [6] = '{8'h3F, 8'h06, 8'h86, 8'h00, 8'h7F, 8'h49};
        int r;

        rows[0] = '{pat: {8'h66, 8'h4F, 8'h5B, 8'h06}, bcd: 16'h4321, dp: 4'b0000, err: 4'b0000};
        rows[1] = '{pat: {8'h7F, 8'h00, 8'h86, 8'h3F}, bcd: 16'h8F10, dp: 4'b0010, err: 4'b0100};
        rows[2] = '{pat: {8'h07, 8'hEF, 8'h6D, 8'h7D}, bcd: 16'h7956, dp: 4'b0100, err: 4'b0000};
        rows[3] = '{pat: {8'hFF, 8'h06, 8'h3F, 8'h49}, bcd: 16'h810F, dp: 4'b1000, err: 4'b0001};

        #2;
        // Table-driven frames, each from a fresh reset
        for (int i = 0; i < 4; i++) begin
            do_reset();
            for (int d = 0; d < N; d++) strobe(d, rows[i].pat[d], S, 1'b1);
            check("tbl_fv_capture_edge", frame_valid, 0);
            wait_frame(1'b1);
            check("tbl_bcd", bcd_out, rows[i].bcd);
            check("tbl_dp", dp_out, rows[i].dp);
            check("tbl_err", err_out, rows[i].err);
            idle(1, 1'b1);
            check("tbl_fv_one_cycle", frame_valid, 0);
        end

        // Pattern change restarts counting: 1,1 then 7,7,7 captures 7
        do_reset();
        strobe(1, 8'h5B, S, 1'b1);
        strobe(2, 8'h4F, S, 1'b1);
        strobe(3, 8'h66, S, 1'b1);
        strobe(0, 8'h06, 2, 1'b1);
        strobe(0, 8'h07, 2, 1'b1);
        idle(1, 1'b1);
        check("restart_no_early", frame_valid, 0);
        strobe(0, 8'h07, 1, 1'b1);
        check("restart_latency", frame_valid, 0);
        idle(1, 1'b1);
        check("restart_fv", frame_valid, 1);
        check("restart_digit0", bcd_out[3:0], 4'h7);
        idle(1, 1'b1);

        // Backpressure: outputs frozen while ready is low and a new frame builds up
        do_reset();
        strobe(0, 8'h3F, S, 1'b0);
        strobe(1, 8'h06, S, 1'b0);
        strobe(2, 8'h5B, S, 1'b0);
        strobe(3, 8'h4F, S, 1'b0);
        wait_frame(1'b0);
        check("hold_first", bcd_out, 16'h3210);
        for (int c = 0; c < 20; c++) begin
            if (c < 12) strobe(c / 3, 8'h7F, 1, 1'b0);
            else idle(1, 1'b0);
            check("hold_fv", frame_valid, 1);
            check("hold_bcd", bcd_out, 16'h3210);
        end
        idle(1, 1'b1);
        check("hold_release", frame_valid, 0);
        idle(1, 1'b0);
        check("hold_next_fv", frame_valid, 1);
        check("hold_next_bcd", bcd_out, 16'h8888);
        idle(1, 1'b1);

        // Bad digit selects are discarded and flagged
        do_reset();
        strobe(1, 8'h5B, S, 1'b1);
        strobe(2, 8'h4F, S, 1'b1);
        strobe(3, 8'h66, S, 1'b1);
        strobe(0, 8'h06, S - 1, 1'b1);
        tick(1'b1, 4'b0011, 8'h06, 1'b1);
        check("sel_multi", sel_err, 1);
        idle(2, 1'b1);
        check("sel_multi_nocount", frame_valid, 0);
        tick(1'b1, 4'b0000, 8'h06, 1'b1);
        idle(2, 1'b1);
        check("sel_zero_nocount", frame_valid, 0);
        check("sel_sticky", sel_err, 1);
        strobe(0, 8'h06, 1, 1'b1);
        idle(1, 1'b1);
        check("sel_then_frame", bcd_out, 16'h4321);
        idle(1, 1'b1);
        strobe(0, 8'h3F, 1, 1'b1);
        do_reset();
        for (int d = 0; d < N - 1; d++) strobe(d, 8'h06, S, 1'b1);
        idle(4, 1'b1);
        check("no_partial_frame", frame_valid, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int d = 0; d < N; d++) cur_seg[d] = pool[$urandom_range(0, 5)];
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 15);
            if (r == 0) cur_an = 4'b0000;
            else if (r == 1) cur_an = 4'b0110;
            else cur_an = 4'(1) << $urandom_range(0, N - 1);
            for (int d = 0; d < N; d++)
                if ($urandom_range(0, 7) == 0) cur_seg[d] = pool[$urandom_range(0, 5)];
            r = 0;
            for (int d = 0; d < N; d++) if (cur_an[d]) r = d;
            tick($urandom_range(0, 3) != 0, cur_an, cur_seg[r], $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_to_bcd_capture.md
Name: seven_seg_to_bcd_capture

Overview:
- Inverse of the display path: samples a multiplexed seven-segment bus (segment pattern plus one-hot digit select) and recovers per-digit BCD values.
- Filters each digit for stability, flags illegal patterns, and presents a complete frame on a valid/ready handshake.
- Used for display readback/self-check on the vending machine front panel and as a scoreboard source in system benches.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CNT, 3, consecutive identical samples per digit required before capture (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  one-cycle strobe; bus sampled only when high.
- seg_in  in  8  segment pattern, bit0=a..bit6=g, bit7=dp, 1=lit.
- an_in  in  NUM_DIGITS  digit select, active-high, one-hot expected.
- frame_valid  out  1  bcd_out/dp_out/err_out hold a complete frame.
- frame_ready  in  1  consumer accepts the frame.
- bcd_out  out  4*NUM_DIGITS  digit i at [4i+3:4i].
- dp_out  out  NUM_DIGITS  decimal point per digit.
- err_out  out  NUM_DIGITS  digit pattern was illegal.
- sel_err  out  1  sticky: sample seen with non-one-hot an_in.

Behaviour:
- Reset (async assert, sync deassert by consumer): all outputs 0; per-digit last pattern 0, counters 0, captured mask 0, state COLLECT.
- Decode on seg_in[6:0], dp ignored: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9. Any other pattern, including 0x00 (blank), -> BCD 4'hF with err bit set.
- Sampling: active only when sample_en=1 and an_in is exactly one-hot.
  - Zero-hot or multi-hot an_in: sample discarded, sel_err set. sel_err clears only on reset.
- Stability filter per digit i, on a valid sample selecting i:
  - If seg_in equals last[i] (all 8 bits), cnt[i] increments, saturating at STABLE_CNT.
  - Otherwise last[i]<=seg_in and cnt[i]<=1.
  - On the cycle cnt[i] reaches STABLE_CNT, either by increment or by reset-to-1 when STABLE_CNT=1, shadow[i]<=decode(seg_in) with dp and err, and captured[i]<=1.
  - Further identical samples do not re-capture; a changed pattern restarts counting.
- FSM, two states:
  - COLLECT: frame_valid=0. When captured mask is all ones, the next cycle loads bcd_out/dp_out/err_out from shadow, clears captured, sets frame_valid=1, goes to PRESENT. Capture-to-frame_valid latency is 1 cycle after the final digit's capture edge.
  - PRESENT: outputs held stable and frame_valid=1 until frame_ready=1 is sampled. Then frame_valid=0 and the FSM returns to COLLECT.
  - Sampling and capture continue during PRESENT into shadow/captured and never disturb the outputs.
  - If captured is already all ones when the FSM returns to COLLECT, the next frame presents on the following cycle.
- frame_ready while in COLLECT is ignored.
- Reset mid-frame: everything returns to the reset values; no partial frame is ever presented.
- Counter width: clog2(STABLE_CNT+1).

Decomposition:
- Shared package: segment bit-position constants, the ten legal pattern constants, BCD_INVALID=4'hF, FSM state encoding.
- One natural sub-module: seg_pattern_decode, a combinational 7-bit pattern -> {err, bcd[3:0]}. Instantiated once on seg_in, since only one digit is sampled per cycle.

Test Plan:
- Reset then drive digits 0..3 with 0x06, 0x5B, 0x4F, 0x66, three strobes each, frame_ready=1. Expect frame_valid for 1 cycle, bcd_out=16'h4321, err_out=0, dp_out=0.
- Digit 0 gets 0x06, 0x06, 0x07, 0x07, 0x07. Expect capture of 7 only after the fifth strobe, not 1.
- Digit 2 gets 0x00 three times, others legal. Expect bcd_out[11:8]=4'hF, err_out=4'b0100.
- Digit 1 gets 0x86 (dp + 1). Expect bcd nibble 1, dp_out[1]=1.
- Hold frame_ready=0 for 20 cycles while new patterns arrive. Expect outputs unchanged; when ready is raised, the next frame presents 1 cycle after returning to COLLECT.
- Strobe with an_in=4'b0011, and separately 4'b0000. Expect sel_err=1, no counter change. Assert rst_n=0 mid-collection: all outputs 0 immediately.
